// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared funct3 encodings, LSU state type and funct3 legality
//               check for the lsu_rmw load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } lsu_state_t;

    // Stores have no unsigned variants, so only B/H/W are legal for them.
    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                   (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_rmw_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_rmw_if
// Description : Core-side request/response and data_memory-side signals of
//               the load/store unit, with core, LSU and memory views.
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_rmw_if;

    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_read_data;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_fault,
               mem_addr, mem_write_data, mem_read, mem_write
    );

    modport mem (
        input  mem_addr, mem_write_data, mem_read, mem_write,
        output mem_read_data
    );

endinterface
`default_nettype wire

// File: rtl/lsu_lane.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane
// Description : Combinational lane logic: load extract/extend and sub-word
//               store merge into the current memory word.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane
    import lsu_pkg::*;
(
    input  wire [2:0]  i_funct3,
    input  wire [1:0]  i_addr_lo,
    input  wire [31:0] i_word,
    input  wire [15:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        // Halfword lane keys on addr[1] only, which also gives natural alignment
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_BU:   o_load_data = {24'd0, w_byte};
            F3_HU:   o_load_data = {16'd0, w_half};
            default: o_load_data = i_word;
        endcase

        o_merge_data = i_word;
        if (i_funct3 == F3_B)
            o_merge_data[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
        else if (i_funct3 == F3_H)
            o_merge_data[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/lsu_rmw.sv
`default_nettype none
// ============================================================================
// Module      : lsu_rmw
// Description : RV32I load/store unit over a word-wide data memory; sub-word
//               stores use a two-cycle read-modify-write.
//               Define LSU_ALIGN_CHECK_EN to fault misaligned/out-of-range
//               accesses instead of silently aligning them.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS_LOG2 = 8
) (
    input  wire   clk,
    input  wire   rst,
    lsu_rmw_if.slave bus
);

    lsu_state_t  r_state;
    logic [31:0] r_rmw_addr;
    logic [31:0] r_rmw_data;

    logic        w_accept;
    logic        w_fault;
    logic        w_access;
    logic        w_sub_store;
    logic [31:0] w_word_addr;
    logic [31:0] w_load_data;
    logic [31:0] w_merge_data;

    assign bus.req_ready = (r_state == IDLE);
    assign w_accept      = bus.req_valid && (r_state == IDLE) && !rst;
    assign w_word_addr   = {bus.req_addr[31:2], 2'b00};
    assign w_sub_store   = bus.req_we &&
                           ((bus.req_funct3 == F3_B) || (bus.req_funct3 == F3_H));

`ifdef LSU_ALIGN_CHECK_EN
    logic w_misalign;
    logic w_out_of_range;

    // Among legal funct3 values, [1:0]==01 is halfword and [1:0]==10 is word
    assign w_misalign     = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                            ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    assign w_out_of_range = |bus.req_addr[31:MEM_WORDS_LOG2+2];
    assign w_fault        = !funct3_legal(bus.req_we, bus.req_funct3) ||
                            w_misalign || w_out_of_range;
`else
    assign w_fault        = !funct3_legal(bus.req_we, bus.req_funct3);
`endif

    assign w_access = w_accept && !w_fault;

    lsu_lane u_lane (
        .i_funct3     (bus.req_funct3),
        .i_addr_lo    (bus.req_addr[1:0]),
        .i_word       (bus.mem_read_data),
        .i_wdata      (bus.req_wdata[15:0]),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    // Reset overrides everything, including an in-flight RMW write-back
    always_comb begin
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.mem_addr       = 32'd0;
        bus.mem_write_data = 32'd0;
        if (!rst) begin
            if (r_state == RMW_WR) begin
                bus.mem_write      = 1'b1;
                bus.mem_addr       = r_rmw_addr;
                bus.mem_write_data = r_rmw_data;
            end else if (w_access) begin
                bus.mem_addr = w_word_addr;
                if (!bus.req_we || w_sub_store) begin
                    bus.mem_read = 1'b1;
                end else begin
                    bus.mem_write      = 1'b1;
                    bus.mem_write_data = bus.req_wdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_rmw_addr     <= 32'd0;
            r_rmw_data     <= 32'd0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= 32'd0;
            bus.resp_fault <= 1'b0;
        end else begin
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= 32'd0;
            bus.resp_fault <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_fault) begin
                            bus.resp_valid <= 1'b1;
                            bus.resp_fault <= 1'b1;
                        end else if (w_sub_store) begin
                            r_rmw_addr <= w_word_addr;
                            r_rmw_data <= w_merge_data;
                            r_state    <= RMW_WR;
                        end else begin
                            bus.resp_valid <= 1'b1;
                            if (!bus.req_we)
                                bus.resp_rdata <= w_load_data;
                        end
                    end
                end
                RMW_WR: begin
                    bus.resp_valid <= 1'b1;
                    r_state        <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_rmw.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_rmw
// Description : Self-checking bench for lsu_rmw: vector table plus RMW and
//               reset-during-RMW sequences, responses checked via scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_rmw;
    import lsu_pkg::*;

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_fault;
        logic [31:0] exp_rdata;
        logic        exp_rd;
        logic        exp_wr;
    } vec_t;

    typedef struct {
        string       name;
        logic        fault;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        preload = 1'b1;
    logic        mon_en = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] mem [256];
    vec_t        vecs [$];
    exp_t        sb [$];
    exp_t        e_mon;

    lsu_rmw_if bus ();

    lsu_rmw #(.MEM_WORDS_LOG2(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign bus.mem_read_data = mem[bus.mem_addr[9:2]];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
            mem[0] <= 32'h8899AABB;
            mem[1] <= 32'h11223344;
            mem[2] <= 32'hA5A5A5A5;
        end else if (bus.mem_write) begin
            mem[bus.mem_addr[9:2]] <= bus.mem_write_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic fault, input logic [31:0] rdata);
        vec_t v;
        v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.exp_fault = fault; v.exp_rdata = rdata;
        v.exp_rd = !fault && !we;
        v.exp_wr = !fault && we;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
    endtask

    task automatic expect_resp(input string name, input logic fault, input logic [31:0] rdata,
                               input int latency);
        exp_t e;
        e.name = name; e.fault = fault; e.rdata = rdata; e.due = cyc + latency;
        sb.push_back(e);
    endtask

    // Response scoreboard and idle-output invariants
    always @(negedge clk) begin
        if (mon_en) begin
            chk("rd_wr_overlap", {31'd0, bus.mem_read & bus.mem_write}, 32'd0);
            if (bus.resp_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_resp: resp_valid=1 with no outstanding request");
                end else begin
                    e_mon = sb.pop_front();
                    chk({e_mon.name, "_latency"}, cyc, e_mon.due);
                    chk({e_mon.name, "_fault"}, {31'd0, bus.resp_fault}, {31'd0, e_mon.fault});
                    chk({e_mon.name, "_rdata"}, bus.resp_rdata, e_mon.rdata);
                end
            end else begin
                chk("idle_resp_fault", {31'd0, bus.resp_fault}, 32'd0);
                chk("idle_resp_rdata", bus.resp_rdata, 32'd0);
                if (sb.size() > 0 && cyc >= sb[0].due) begin
                    e_mon = sb.pop_front();
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s_missing: resp_valid=0 at cycle %0d, expected 1", e_mon.name, cyc);
                end
            end
        end
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;

        add_vec("lb_3",      1'b0, F3_B,  32'h3,   32'h0,        1'b0, 32'hFFFFFF88);
        add_vec("lbu_3",     1'b0, F3_BU, 32'h3,   32'h0,        1'b0, 32'h00000088);
        add_vec("lh_2",      1'b0, F3_H,  32'h2,   32'h0,        1'b0, 32'hFFFF8899);
        add_vec("lhu_0",     1'b0, F3_HU, 32'h0,   32'h0,        1'b0, 32'h0000AABB);
        add_vec("lb_0",      1'b0, F3_B,  32'h0,   32'h0,        1'b0, 32'hFFFFFFBB);
        add_vec("sw_10",     1'b1, F3_W,  32'h10,  32'hDEADBEEF, 1'b0, 32'h0);
        add_vec("lw_10",     1'b0, F3_W,  32'h10,  32'h0,        1'b0, 32'hDEADBEEF);
        add_vec("ld_f3_3",   1'b0, 3'd3,  32'h0,   32'h0,        1'b1, 32'h0);
        add_vec("st_f3_4",   1'b1, 3'd4,  32'h0,   32'h0,        1'b1, 32'h0);
        add_vec("ld_f3_6",   1'b0, 3'd6,  32'h0,   32'h0,        1'b1, 32'h0);
        add_vec("st_f3_3",   1'b1, 3'd3,  32'h0,   32'h0,        1'b1, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
        add_vec("lw_6",      1'b0, F3_W,  32'h6,   32'h0,        1'b1, 32'h0);
        add_vec("lh_1",      1'b0, F3_H,  32'h1,   32'h0,        1'b1, 32'h0);
        add_vec("lw_400",    1'b0, F3_W,  32'h400, 32'h0,        1'b1, 32'h0);
        add_vec("sh_5",      1'b1, F3_H,  32'h5,   32'h0000CAFE, 1'b1, 32'h0);
`else
        add_vec("lw_6",      1'b0, F3_W,  32'h6,   32'h0,        1'b0, 32'h11223344);
        add_vec("lh_1",      1'b0, F3_H,  32'h1,   32'h0,        1'b0, 32'hFFFFAABB);
        add_vec("lw_400",    1'b0, F3_W,  32'h400, 32'h0,        1'b0, 32'h8899AABB);
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready",  {31'd0, bus.req_ready},  32'd1);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_resp_fault", {31'd0, bus.resp_fault}, 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata,          32'd0);
        chk("rst_mem_read",   {31'd0, bus.mem_read},   32'd0);
        chk("rst_mem_write",  {31'd0, bus.mem_write},  32'd0);
        chk("rst_mem_addr",   bus.mem_addr,            32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        preload = 1'b0;
        mon_en = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            drive(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
            expect_resp(vecs[i].name, vecs[i].exp_fault, vecs[i].exp_rdata, 1);
            @(negedge clk);
            chk({vecs[i].name, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
            chk({vecs[i].name, "_mem_read"}, {31'd0, bus.mem_read}, {31'd0, vecs[i].exp_rd});
            chk({vecs[i].name, "_mem_write"}, {31'd0, bus.mem_write}, {31'd0, vecs[i].exp_wr});
            if (vecs[i].exp_rd || vecs[i].exp_wr)
                chk({vecs[i].name, "_mem_addr"}, bus.mem_addr, {vecs[i].addr[31:2], 2'b00});
            else
                chk({vecs[i].name, "_mem_addr"}, bus.mem_addr, 32'd0);
            chk({vecs[i].name, "_mem_wdata"}, bus.mem_write_data,
                vecs[i].exp_wr ? vecs[i].wdata : 32'd0);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("sw_mem_word4", mem[4], 32'hDEADBEEF);

        // SB byte 1 of word 0: read at T, write-back at T+1, response at T+2
        @(posedge clk); #1;
        drive(1'b1, F3_B, 32'h1, 32'h12345677);
        expect_resp("sb_1", 1'b0, 32'h0, 2);
        @(negedge clk);
        chk("sb_t_mem_read",  {31'd0, bus.mem_read},  32'd1);
        chk("sb_t_mem_write", {31'd0, bus.mem_write}, 32'd0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("sb_t1_ready",     {31'd0, bus.req_ready}, 32'd0);
        chk("sb_t1_mem_read",  {31'd0, bus.mem_read},  32'd0);
        chk("sb_t1_mem_write", {31'd0, bus.mem_write}, 32'd1);
        chk("sb_t1_mem_wdata", bus.mem_write_data,     32'h889977BB);
        chk("sb_t1_mem_addr",  bus.mem_addr,           32'h0);
        // New request accepted in the same cycle the SB response appears
        @(posedge clk); #1;
        drive(1'b0, F3_W, 32'h0, 32'h0);
        expect_resp("lw_after_sb", 1'b0, 32'h889977BB, 1);
        @(negedge clk);
        chk("sb_t2_ready",    {31'd0, bus.req_ready}, 32'd1);
        chk("sb_t2_mem_read", {31'd0, bus.mem_read},  32'd1);
        chk("sb_mem_word0",   mem[0],                 32'h889977BB);

        // SH upper half of word 1
        @(posedge clk); #1;
        drive(1'b1, F3_H, 32'h6, 32'h0000CAFE);
        expect_resp("sh_6", 1'b0, 32'h0, 2);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("sh_t1_mem_wdata", bus.mem_write_data, 32'hCAFE3344);
        chk("sh_t1_mem_addr",  bus.mem_addr,       32'h4);
        @(posedge clk); #1;
        @(negedge clk);
        chk("sh_mem_word1", mem[1], 32'hCAFE3344);

        // Reset lands on the RMW_WR cycle of an SH: the write must be abandoned
        @(posedge clk); #1;
        drive(1'b1, F3_H, 32'h8, 32'h00005555);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rstrmw_mem_write", {31'd0, bus.mem_write}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstrmw_ready",      {31'd0, bus.req_ready},  32'd1);
        chk("rstrmw_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rstrmw_mem_word2",  mem[2],                  32'hA5A5A5A5);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sb_queue_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
